// File: rtl/math_pkg.sv
// Shared fixed-point math helpers: flag bundle and two's-complement range constants.
package math_pkg;

    localparam int ABS_MAX_W = 256;

    typedef struct packed {
        logic neg;
        logic ovf;
    } abs_flags_t;

    // Returns 100...0 for the given width, zero-extended to ABS_MAX_W bits.
    function automatic logic [ABS_MAX_W-1:0] abs_most_neg(input int width);
        return ABS_MAX_W'(1) << (width - 1);
    endfunction

    function automatic logic [ABS_MAX_W-1:0] abs_max_pos(input int width);
        return abs_most_neg(width) - ABS_MAX_W'(1);
    endfunction

endpackage

// File: rtl/abs_pipe_stage.sv
// One pipeline register stage of abs_pipe: valid bit plus data and flags.
module abs_pipe_stage
    import math_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  abs_flags_t       in_flags,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output abs_flags_t       flags
);

    // Payload only moves with a real item, so a bubble never disturbs held data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            flags <= '0;
        end else if (load) begin
            valid <= in_valid;
            if (in_valid) begin
                data  <= in_data;
                flags <= in_flags;
            end
        end
    end

endmodule

// File: rtl/abs_pipe.sv
// Pipelined absolute value with valid/ready flow control and bubble collapsing.
module abs_pipe
    import math_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int STAGES   = 2,
    parameter int SATURATE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_neg,
    output logic             out_ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam logic [WIDTH-1:0] MOST_NEG = WIDTH'(abs_most_neg(WIDTH));
    localparam logic [WIDTH-1:0] MAX_POS  = WIDTH'(abs_max_pos(WIDTH));

    logic [STAGES:0]            vld_pipe;
    logic [STAGES:0][WIDTH-1:0] data_pipe;
    abs_flags_t [STAGES:0]      flag_pipe;
    logic [STAGES:1]            adv;

    abs_flags_t       in_flags;
    logic [WIDTH-1:0] mag;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_data;
    abs_flags_t       s1_flags;

    always_comb begin
        in_flags.neg = in_data[WIDTH-1];
        in_flags.ovf = in_data[WIDTH-1] && (in_data[WIDTH-2:0] == '0);
        mag          = in_flags.neg ? (~in_data + WIDTH'(1)) : in_data;
        if (in_flags.ovf) mag = (SATURATE != 0) ? MAX_POS : MOST_NEG;
    end

    // Load enables ripple back from the consumer; an empty stage always loads.
    always_comb begin : advance
        logic downstream;
        downstream = out_ready;
        adv        = '0;
        for (int k = STAGES; k >= 1; k--) begin
            adv[k]     = !vld_pipe[k] || downstream;
            downstream = adv[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_flags <= '0;
        end else if (adv[1]) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data  <= mag;
                s1_flags <= in_flags;
            end
        end
    end

    assign vld_pipe[0]  = in_valid;
    assign data_pipe[0] = mag;
    assign flag_pipe[0] = in_flags;
    assign vld_pipe[1]  = s1_valid;
    assign data_pipe[1] = s1_data;
    assign flag_pipe[1] = s1_flags;

    for (genvar k = 2; k <= STAGES; k++) begin : g_stage
        abs_pipe_stage #(.WIDTH(WIDTH)) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (adv[k]),
            .in_valid (vld_pipe[k-1]),
            .in_data  (data_pipe[k-1]),
            .in_flags (flag_pipe[k-1]),
            .valid    (vld_pipe[k]),
            .data     (data_pipe[k]),
            .flags    (flag_pipe[k])
        );
    end

    assign in_ready  = adv[1];
    assign out_valid = vld_pipe[STAGES];
    assign out_data  = data_pipe[STAGES];
    assign out_neg   = flag_pipe[STAGES].neg;
    assign out_ovf   = flag_pipe[STAGES].ovf;

endmodule

// File: tb/tb_abs_pipe.sv
// Directed and randomized checks of abs_pipe across several parameter sets.
module tb_abs_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // A: 32b/2 stages/saturate, B: same inputs but wrapping
    logic [31:0] a_in_data = '0;
    logic        a_in_valid = 1'b0, a_out_ready = 1'b1;
    logic        a_in_ready, a_out_neg, a_out_ovf, a_out_valid;
    logic [31:0] a_out_data, b_out_data;
    logic        b_in_ready, b_out_neg, b_out_ovf, b_out_valid;
    // C: 32b/3 stages backpressure
    logic [31:0] c_in_data = '0;
    logic        c_in_valid = 1'b0, c_out_ready = 1'b1;
    logic        c_in_ready, c_out_neg, c_out_ovf, c_out_valid;
    logic [31:0] c_out_data;
    // D: 8b/3 stages random
    logic [7:0]  d_in_data = '0;
    logic        d_in_valid = 1'b0, d_out_ready = 1'b1;
    logic        d_in_ready, d_out_neg, d_out_ovf, d_out_valid;
    logic [7:0]  d_out_data;
    // E: 2b/1 stage
    logic [1:0]  e_in_data = '0;
    logic        e_in_valid = 1'b0, e_out_ready = 1'b1;
    logic        e_in_ready, e_out_neg, e_out_ovf, e_out_valid;
    logic [1:0]  e_out_data;

    abs_pipe #(.WIDTH(32), .STAGES(2), .SATURATE(1)) u_a (
        .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .out_data(a_out_data), .out_neg(a_out_neg),
        .out_ovf(a_out_ovf), .out_valid(a_out_valid), .out_ready(a_out_ready));
    abs_pipe #(.WIDTH(32), .STAGES(2), .SATURATE(0)) u_b (
        .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
        .in_ready(b_in_ready), .out_data(b_out_data), .out_neg(b_out_neg),
        .out_ovf(b_out_ovf), .out_valid(b_out_valid), .out_ready(a_out_ready));
    abs_pipe #(.WIDTH(32), .STAGES(3), .SATURATE(1)) u_c (
        .clk(clk), .rst_n(rst_n), .in_data(c_in_data), .in_valid(c_in_valid),
        .in_ready(c_in_ready), .out_data(c_out_data), .out_neg(c_out_neg),
        .out_ovf(c_out_ovf), .out_valid(c_out_valid), .out_ready(c_out_ready));
    abs_pipe #(.WIDTH(8), .STAGES(3), .SATURATE(1)) u_d (
        .clk(clk), .rst_n(rst_n), .in_data(d_in_data), .in_valid(d_in_valid),
        .in_ready(d_in_ready), .out_data(d_out_data), .out_neg(d_out_neg),
        .out_ovf(d_out_ovf), .out_valid(d_out_valid), .out_ready(d_out_ready));
    abs_pipe #(.WIDTH(2), .STAGES(1), .SATURATE(1)) u_e (
        .clk(clk), .rst_n(rst_n), .in_data(e_in_data), .in_valid(e_in_valid),
        .in_ready(e_in_ready), .out_data(e_out_data), .out_neg(e_out_neg),
        .out_ovf(e_out_ovf), .out_valid(e_out_valid), .out_ready(e_out_ready));

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic test_reset;
        #3;
        vectors++;
        if ({a_out_valid, b_out_valid, c_out_valid, d_out_valid, e_out_valid} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_valid: got %b want 00000",
                     {a_out_valid, b_out_valid, c_out_valid, d_out_valid, e_out_valid});
        end
        vectors++;
        if ({a_out_data, a_out_neg, a_out_ovf, c_out_data, d_out_data, e_out_data} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got a=%h c=%h d=%h e=%h want 0",
                     a_out_data, c_out_data, d_out_data, e_out_data);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++;
        if ({a_in_ready, c_in_ready, d_in_ready, e_in_ready} !== 4'b1111) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b want 1111",
                     {a_in_ready, c_in_ready, d_in_ready, e_in_ready});
        end
    endtask

    task automatic test_free_flow;
        logic [31:0] ins[3];
        logic [31:0] exp_d[3];
        logic        exp_n[3];
        ins   = '{32'd5, 32'hFFFF_FFFB, 32'd0};
        exp_d = '{32'd5, 32'd5, 32'd0};
        exp_n = '{1'b0, 1'b1, 1'b0};
        a_out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i < 2 || i == 5) begin
                vectors++;
                if (a_out_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL ff_idle[%0d]: out_valid got %b want 0", i, a_out_valid);
                end
            end else begin
                vectors++;
                if (a_out_valid !== 1'b1 || a_out_data !== exp_d[i-2] || a_out_neg !== exp_n[i-2] ||
                    a_out_ovf !== 1'b0) begin
                    miscompares++;
                    $display("FAIL ff_a[%0d]: got v=%b d=%h n=%b o=%b want v=1 d=%h n=%b o=0",
                             i - 2, a_out_valid, a_out_data, a_out_neg, a_out_ovf, exp_d[i-2], exp_n[i-2]);
                end
                vectors++;
                if (b_out_valid !== 1'b1 || b_out_data !== exp_d[i-2] || b_out_neg !== exp_n[i-2]) begin
                    miscompares++;
                    $display("FAIL ff_b[%0d]: got v=%b d=%h n=%b want v=1 d=%h n=%b",
                             i - 2, b_out_valid, b_out_data, b_out_neg, exp_d[i-2], exp_n[i-2]);
                end
            end
            if (i < 3) begin
                a_in_valid = 1'b1;
                a_in_data  = ins[i];
                #1;
                vectors++;
                if (a_in_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL ff_in_ready[%0d]: got %b want 1", i, a_in_ready);
                end
            end else begin
                a_in_valid = 1'b0;
                a_in_data  = '0;
            end
        end
    endtask

    task automatic test_most_neg;
        logic [31:0] ins[3];
        logic [31:0] exp_a[3];
        logic [31:0] exp_b[3];
        logic        exp_n[3];
        logic        exp_o[3];
        ins   = '{32'h8000_0000, 32'h8000_0001, 32'h7FFF_FFFF};
        exp_a = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
        exp_b = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
        exp_n = '{1'b1, 1'b1, 1'b0};
        exp_o = '{1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                vectors++;
                if (a_out_valid !== 1'b1 || a_out_data !== exp_a[i-2] || a_out_neg !== exp_n[i-2] ||
                    a_out_ovf !== exp_o[i-2]) begin
                    miscompares++;
                    $display("FAIL mn_sat[%0d]: got v=%b d=%h n=%b o=%b want v=1 d=%h n=%b o=%b",
                             i - 2, a_out_valid, a_out_data, a_out_neg, a_out_ovf,
                             exp_a[i-2], exp_n[i-2], exp_o[i-2]);
                end
                vectors++;
                if (b_out_valid !== 1'b1 || b_out_data !== exp_b[i-2] || b_out_neg !== exp_n[i-2] ||
                    b_out_ovf !== exp_o[i-2]) begin
                    miscompares++;
                    $display("FAIL mn_wrap[%0d]: got v=%b d=%h n=%b o=%b want v=1 d=%h n=%b o=%b",
                             i - 2, b_out_valid, b_out_data, b_out_neg, b_out_ovf,
                             exp_b[i-2], exp_n[i-2], exp_o[i-2]);
                end
            end
            a_in_valid = (i < 3);
            a_in_data  = (i < 3) ? ins[i] : 32'd0;
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        int next, accepted, exp_out, cyc;
        logic [5:0] ready_seen;
        next = 1;
        accepted = 0;
        c_out_ready = 1'b0;
        ready_seen = '0;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            c_in_valid = 1'b1;
            c_in_data  = next;
            #1;
            ready_seen[i] = c_in_ready;
            if (c_in_ready) begin
                accepted++;
                next++;
            end
            @(negedge clk);
        end
        vectors++;
        if (accepted != 3 || ready_seen !== 6'b000111) begin
            miscompares++;
            $display("FAIL bp_fill: accepted %0d ready %b want 3 ready 000111", accepted, ready_seen);
        end
        vectors++;
        if (c_out_valid !== 1'b1 || c_out_data !== 32'd1) begin
            miscompares++;
            $display("FAIL bp_hold: got v=%b d=%h want v=1 d=1", c_out_valid, c_out_data);
        end
        c_out_ready = 1'b1;
        exp_out = 1;
        cyc = 0;
        while (exp_out <= 10 && cyc < 40) begin
            vectors++;
            if (c_out_valid !== 1'b1 || c_out_data !== 32'(exp_out)) begin
                miscompares++;
                $display("FAIL bp_drain[%0d]: got v=%b d=%h want v=1 d=%h",
                         cyc, c_out_valid, c_out_data, 32'(exp_out));
            end
            exp_out++;
            c_in_valid = (next <= 10);
            c_in_data  = next;
            #1;
            if (c_in_valid && c_in_ready) next++;
            @(negedge clk);
            cyc++;
        end
        c_in_valid = 1'b0;
        vectors++;
        if (c_out_valid !== 1'b0 || exp_out != 11 || next != 11) begin
            miscompares++;
            $display("FAIL bp_end: got v=%b emitted=%0d sent=%0d want v=0 emitted=10 sent=10",
                     c_out_valid, exp_out - 1, next - 1);
        end
    endtask

    task automatic test_random;
        logic [9:0] q[$];
        logic [9:0] exp_e;
        logic [7:0] stim, m, prev_data;
        logic       prev_stall, prev_neg, prev_ovf;
        int         sent, recv, cyc, sv, av;
        sent = 0;
        recv = 0;
        cyc = 0;
        prev_stall = 1'b0;
        prev_data = '0;
        prev_neg = 1'b0;
        prev_ovf = 1'b0;
        stim = 8'($urandom_range(0, 255));
        while (recv < 10000 && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            if (prev_stall) begin
                vectors++;
                if (d_out_valid !== 1'b1 || d_out_data !== prev_data || d_out_neg !== prev_neg ||
                    d_out_ovf !== prev_ovf) begin
                    miscompares++;
                    $display("FAIL rnd_stable: got v=%b d=%h want v=1 d=%h", d_out_valid, d_out_data, prev_data);
                end
            end
            d_out_ready = ($urandom_range(0, 3) != 0);
            d_in_valid  = (sent < 10000) && ($urandom_range(0, 3) != 0);
            d_in_data   = stim;
            #1;
            if (d_out_valid && d_out_ready) begin
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rnd_extra: got d=%h want no item", d_out_data);
                end else begin
                    exp_e = q.pop_front();
                    if ({d_out_ovf, d_out_neg, d_out_data} !== exp_e) begin
                        miscompares++;
                        $display("FAIL rnd_data[%0d]: got o=%b n=%b d=%h want o=%b n=%b d=%h",
                                 recv, d_out_ovf, d_out_neg, d_out_data, exp_e[9], exp_e[8], exp_e[7:0]);
                    end
                end
                recv++;
            end
            if (d_in_valid && d_in_ready) begin
                sv = stim[7] ? int'(stim) - 256 : int'(stim);
                av = (sv < 0) ? -sv : sv;
                if (av > 127) av = 127;
                m = av[7:0];
                q.push_back({(sv == -128), (sv < 0), m});
                sent++;
                stim = 8'($urandom_range(0, 255));
            end
            prev_stall = d_out_valid && !d_out_ready;
            prev_data  = d_out_data;
            prev_neg   = d_out_neg;
            prev_ovf   = d_out_ovf;
        end
        d_in_valid = 1'b0;
        d_out_ready = 1'b1;
        vectors++;
        if (recv != 10000 || sent != 10000) begin
            miscompares++;
            $display("FAIL rnd_count: got sent=%0d recv=%0d want 10000/10000", sent, recv);
        end
    endtask

    task automatic test_reset_mid;
        a_out_ready = 1'b1;
        @(negedge clk);
        a_in_valid = 1'b1;
        a_in_data  = 32'hFFFF_FFFD;
        @(negedge clk);
        a_in_data  = 32'd4;
        @(negedge clk);
        a_in_valid = 1'b0;
        vectors++;
        if (a_out_valid !== 1'b1 || a_out_data !== 32'd3) begin
            miscompares++;
            $display("FAIL rm_pre: got v=%b d=%h want v=1 d=3", a_out_valid, a_out_data);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({a_out_valid, a_out_neg, a_out_ovf, b_out_valid} !== 4'b0 || a_out_data !== '0 ||
            b_out_data !== '0) begin
            miscompares++;
            $display("FAIL rm_async: got v=%b d=%h n=%b o=%b bv=%b bd=%h want all 0",
                     a_out_valid, a_out_data, a_out_neg, a_out_ovf, b_out_valid, b_out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 2) begin
                vectors++;
                if (a_out_valid !== 1'b1 || a_out_data !== 32'd7 || a_out_neg !== 1'b1) begin
                    miscompares++;
                    $display("FAIL rm_after: got v=%b d=%h n=%b want v=1 d=7 n=1",
                             a_out_valid, a_out_data, a_out_neg);
                end
            end else begin
                vectors++;
                if (a_out_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rm_stale[%0d]: got v=%b d=%h want v=0", i, a_out_valid, a_out_data);
                end
            end
            a_in_valid = (i == 0);
            a_in_data  = (i == 0) ? 32'hFFFF_FFF9 : 32'd0;
        end
    endtask

    task automatic test_edge_width;
        logic [1:0] ins[4];
        logic [1:0] exp_d[4];
        logic       exp_n[4];
        logic       exp_o[4];
        ins   = '{2'b10, 2'b11, 2'b00, 2'b01};
        exp_d = '{2'd1, 2'd1, 2'd0, 2'd1};
        exp_n = '{1'b1, 1'b1, 1'b0, 1'b0};
        exp_o = '{1'b1, 1'b0, 1'b0, 1'b0};
        e_out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i >= 1 && i <= 4) begin
                vectors++;
                if (e_out_valid !== 1'b1 || e_out_data !== exp_d[i-1] || e_out_neg !== exp_n[i-1] ||
                    e_out_ovf !== exp_o[i-1]) begin
                    miscompares++;
                    $display("FAIL ew[%0d]: got v=%b d=%b n=%b o=%b want v=1 d=%b n=%b o=%b",
                             i - 1, e_out_valid, e_out_data, e_out_neg, e_out_ovf,
                             exp_d[i-1], exp_n[i-1], exp_o[i-1]);
                end
            end else begin
                vectors++;
                if (e_out_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL ew_idle[%0d]: got v=%b want 0", i, e_out_valid);
                end
            end
            e_in_valid = (i < 4);
            e_in_data  = (i < 4) ? ins[i] : 2'b00;
        end
    endtask

    initial begin
        test_reset();
        test_free_flow();
        test_most_neg();
        test_backpressure();
        test_edge_width();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/abs_pipe.md
# abs_pipe

Parametrised, pipelined absolute-value unit with valid/ready flow control on both sides. It generalises the free-running 32-bit registered `abs`: data width and pipeline depth are configurable, most-negative handling is selectable, and the pipeline stalls cleanly under downstream backpressure. It sits in the fixed-point math datapath between a stimulus or arithmetic source and any consumer that may stall.

## Interface
- `WIDTH`, 32: operand and result width in bits; must be at least 2.
- `STAGES`, 2: number of register stages; must be at least 1. This is the latency with no stall.
- `SATURATE`, 1: 1 clamps the most-negative input to the maximum positive value; 0 wraps (two's-complement negate).
- `clk`  in  1  clock; all registers update on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  WIDTH  signed two's-complement operand.
- `in_valid`  in  1  operand present.
- `in_ready`  out  1  unit accepts the operand this cycle.
- `out_data`  out  WIDTH  |in_data|, handled according to `SATURATE`.
- `out_neg`  out  1  the original operand was negative.
- `out_ovf`  out  1  the operand was the most-negative value (-2^(WIDTH-1)).
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer accepts the result.

## Operation
- A transfer occurs on an edge where valid and ready are both 1, on each side independently.
- Stage 1 captures the operand and computes, combinationally from the operand:
  - `neg` = the sign bit.
  - `ovf` = sign bit is 1 and all other bits are 0.
  - magnitude = `neg` ? (~x + 1) : x.
- If `ovf` and `SATURATE`=1: magnitude = 2^(WIDTH-1)-1, i.e. 0111…1.
- If `ovf` and `SATURATE`=0: magnitude = 100…0, the input unchanged. `out_ovf` is still asserted.
- Stages 2..STAGES carry data, `neg`, `ovf` and a per-stage valid bit.
- Per-stage advance:
  - Stage k loads when stage k is empty or stage k is unloading.
  - The last stage unloads when `out_ready` is 1.
- `in_ready` = !valid[1] || advance[1]. Bubbles are collapsed: an empty stage never blocks upstream.
- `out_*` are driven directly from the last stage registers.
- Data in a stalled stage holds bit-exact until that stage unloads.
- Results leave in input order; none is lost or duplicated.
- Reset: all valid bits are cleared and data, `neg` and `ovf` registers go to 0.
  - `out_valid`=0, `out_data`=0, `out_neg`=0, `out_ovf`=0.
  - `in_ready`=1 from the first cycle after reset is released.
  - Reset asserted mid-operation discards every in-flight item. No output handshake happens for them.

## Timing
- Latency: an operand accepted at edge N appears with `out_valid`=1 after edge N+STAGES−1, and is held from that point, when the pipeline is not stalled.
- Throughput: one result per cycle while `out_ready`=1.
- Stall with `out_ready`=0:
  - The pipeline fills, then `in_ready` falls.
  - The unit holds at most STAGES items.
  - `in_ready` reaches 0 in the same cycle that all stages are valid and `out_ready`=0.
- `in_ready` depends combinationally on `out_ready`; the ripple path through the STAGES advance terms is accepted.
- Simultaneous load and unload of a full stage is permitted: the stage is replaced with no bubble.
- `out_valid` never deasserts without a handshake, and `out_data` never changes while `out_valid`=1 and `out_ready`=0.

## Structure
- Package `math_pkg` holds:
  - the function `abs_most_neg(WIDTH)`;
  - the function `abs_max_pos(WIDTH)`;
  - the flag-bundle typedef (`neg`, `ovf`).
- Sub-module `abs_pipe_stage`: one register stage with valid bit, load enable, and pass-through of data and flags. It is instantiated STAGES−1 times in a generate loop after the compute stage.
- The compute logic stays in `abs_pipe`. No other sub-modules.

## Test plan
- Free-flow, WIDTH=32, STAGES=2:
  - inputs 5, −5, 0 → outputs 5, 5, 0;
  - `out_neg` = 0, 1, 0;
  - first `out_valid` appears 2 edges after the first accept.
- Most-negative input 0x80000000:
  - SATURATE=1 → out_data=0x7FFFFFFF, out_ovf=1, out_neg=1.
  - SATURATE=0 → out_data=0x80000000, out_ovf=1.
- Backpressure, STAGES=3:
  - hold `out_ready`=0 and stream 1..10;
  - exactly 3 items are accepted, then `in_ready`=0;
  - release `out_ready` → 1..10 emerge in order, one per cycle, none lost.
- Random valid/ready toggling, 10,000 random WIDTH=8 operands: the output stream equals a reference-model stream in order, and `out_data` is stable while stalled.
- Reset mid-stream:
  - assert `rst_n`=0 with 2 items in flight;
  - `out_valid` drops to 0 immediately (asynchronously) and the outputs read 0;
  - after release, in=−7 → out=7 with no stale item emitted.
- Edge widths: WIDTH=2, STAGES=1; inputs −2, −1, 0, 1 → 1 (ovf, SATURATE=1), 1, 0, 1; latency 1 edge.
